mandelbrot_scan_ctrl: RTL

MANDELBROT_SCAN_CTRL -- requirements
Module: mandelbrot_scan_ctrl

---
 rtl/mandelbrot_scan_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/mandelbrot_scan_ctrl.sv
// Raster-scan controller for a Mandelbrot iteration core: walks a frame of pixels,
// launches the core per pixel and hands each iteration count to a ready/valid consumer.
module mandelbrot_scan_ctrl #(
    parameter int BITWIDTH = 11,
    parameter int CTRWIDTH = 7,
    parameter int XBITS    = 6,
    parameter int YBITS    = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic                frame_abort,
    input  logic [BITWIDTH-1:0] cfg_cr0,
    input  logic [BITWIDTH-1:0] cfg_ci0,
    input  logic [BITWIDTH-1:0] cfg_step,
    input  logic [XBITS-1:0]    cfg_last_x,
    input  logic [YBITS-1:0]    cfg_last_y,
    output logic                core_start,
    output logic [BITWIDTH-1:0] core_cr,
    output logic [BITWIDTH-1:0] core_ci,
    input  logic                core_done,
    input  logic [CTRWIDTH-1:0] core_ctr,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [CTRWIDTH-1:0] pix_ctr,
    output logic [XBITS-1:0]    pix_x,
    output logic [YBITS-1:0]    pix_y,
    output logic                pix_last,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, EMIT} state_t;

    state_t              state, state_nxt;
    logic [BITWIDTH-1:0] cr, ci, cr0_q, step_q;
    logic [XBITS-1:0]    x, last_x_q;
    logic [YBITS-1:0]    y, last_y_q;
    logic                at_last, accept, begin_frame, capture;

    assign at_last     = (x == last_x_q) && (y == last_y_q);
    assign begin_frame = (state == IDLE) && frame_start && !frame_abort;
    assign capture     = (state == WAIT) && core_done && !frame_abort;
    assign accept      = (state == EMIT) && pix_ready && !frame_abort;

    // Abort masks the outward strobes in the same cycle so nothing leaks on the way to IDLE.
    assign core_start = (state == LAUNCH) && !frame_abort;
    assign pix_valid  = (state == EMIT) && !frame_abort;
    assign pix_last   = pix_valid && at_last;
    assign busy       = (state != IDLE);
    assign core_cr    = cr;
    assign core_ci    = ci;

    // NOTE: state_nxt is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (core_done) state_nxt = EMIT;
            EMIT:    if (pix_ready) state_nxt = at_last ? IDLE : LAUNCH;
            default: state_nxt = IDLE;
        endcase
        if (frame_abort) state_nxt = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Configuration is snapshotted at frame acceptance; the live cfg_* pins are
    // never consulted again until the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cr       <= '0;
            ci       <= '0;
            cr0_q    <= '0;
            step_q   <= '0;
            x        <= '0;
            y        <= '0;
            last_x_q <= '0;
            last_y_q <= '0;
        end else if (begin_frame) begin
            cr       <= cfg_cr0;
            ci       <= cfg_ci0;
            cr0_q    <= cfg_cr0;
            step_q   <= cfg_step;
            x        <= '0;
            y        <= '0;
            last_x_q <= cfg_last_x;
            last_y_q <= cfg_last_y;
        end else if (accept && !at_last) begin
            if (x != last_x_q) begin
                x  <= x + 1'b1;
                cr <= cr + step_q;
            end else begin
                x  <= '0;
                cr <= cr0_q;
                y  <= y + 1'b1;
                ci <= ci + step_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_ctr <= '0;
            pix_x   <= '0;
            pix_y   <= '0;
        end else if (capture) begin
            pix_ctr <= core_ctr;
            pix_x   <= x;
            pix_y   <= y;
        end
    end

endmodule
